// File: rtl/led_button_ctrl.sv
// Push-button front end for the LED step counter: synchronises and debounces the step and
// direction buttons. Define AUTO_REPEAT_EN to build the hold-to-repeat step behaviour.
module led_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_step,
  input  logic btn_dir,
  output logic step_pulse,
  output logic reverse,
  output logic step_held
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_cfg
    $error("led_button_ctrl: DEBOUNCE_CYCLES>=2, HOLD_CYCLES>=1, REPEAT_CYCLES>=2 required");
  end

`ifdef AUTO_REPEAT_EN
  typedef enum logic [2:0] {S_IDLE, S_DB_PRESS, S_HELD, S_REPEAT, S_DB_REL} state_t;

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic              w_hold_done;
  logic              w_rep_done;

  assign w_hold_done = (r_hold_cnt == HOLD_LAST);
  assign w_rep_done  = (r_rep_cnt == REP_LAST);
`else
  typedef enum logic [1:0] {S_IDLE, S_DB_PRESS, S_HELD, S_DB_REL} state_t;
`endif

  logic [1:0]      r_step_sync;
  logic [1:0]      r_dir_sync;
  logic            w_step_lvl;
  logic            w_dir_lvl;

  state_t          r_state;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_step_held;
  logic            w_db_done;
  logic            w_step_due;

  logic [DB_W-1:0] r_dir_cnt;
  logic            r_dir_db;
  logic            r_reverse;
  logic            r_step_pulse;
  logic            r_pulse_defer;
  logic            w_dir_accept;
  logic            w_dir_toggle;

  // NOTE: reset is synchronous and active-low, so it only takes effect on a clock edge;
  // a button still held when reset lifts is simply re-synchronised and re-debounced.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_step_sync <= '0;
      r_dir_sync  <= '0;
    end else begin
      r_step_sync <= {r_step_sync[0], btn_step};
      r_dir_sync  <= {r_dir_sync[0], btn_dir};
    end
  end

  assign w_step_lvl = r_step_sync[1];
  assign w_dir_lvl  = r_dir_sync[1];
  assign w_db_done  = (r_db_cnt == DB_LAST);

  // A step pulse falls due on the edge the FSM accepts a press or a repeat period expires.
  always_comb begin
    w_step_due = 1'b0;
    if (w_step_lvl) begin
      case (r_state)
        S_DB_PRESS: w_step_due = w_db_done;
`ifdef AUTO_REPEAT_EN
        S_HELD:     w_step_due = w_hold_done;
        S_REPEAT:   w_step_due = w_rep_done;
`endif
        default:    w_step_due = 1'b0;
      endcase
    end
  end

  // NOTE: every register here is assigned with <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_db_cnt    <= '0;
      r_step_held <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_hold_cnt  <= '0;
      r_rep_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_db_cnt <= '0;
          if (w_step_lvl) r_state <= S_DB_PRESS;
        end
        S_DB_PRESS: begin
          if (!w_step_lvl) begin
            r_state  <= S_IDLE;
            r_db_cnt <= '0;
          end else if (w_db_done) begin
            r_state     <= S_HELD;
            r_db_cnt    <= '0;
            r_step_held <= 1'b1;
`ifdef AUTO_REPEAT_EN
            r_hold_cnt  <= '0;
`endif
          end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
          end
        end
        S_HELD: begin
          if (!w_step_lvl) begin
            r_state  <= S_DB_REL;
            r_db_cnt <= '0;
          end
`ifdef AUTO_REPEAT_EN
          else if (w_hold_done) begin
            r_state    <= S_REPEAT;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
          end
`endif
        end
`ifdef AUTO_REPEAT_EN
        S_REPEAT: begin
          if (!w_step_lvl) begin
            r_state   <= S_DB_REL;
            r_db_cnt  <= '0;
            r_rep_cnt <= '0;
          end else if (w_rep_done) begin
            r_rep_cnt <= '0;
          end else begin
            r_rep_cnt <= r_rep_cnt + REP_ONE;
          end
        end
`endif
        S_DB_REL: begin
          // A bounce back high resumes the hold without a new pulse.
          if (w_step_lvl) begin
            r_state    <= S_HELD;
            r_db_cnt   <= '0;
`ifdef AUTO_REPEAT_EN
            r_hold_cnt <= '0;
`endif
          end else if (w_db_done) begin
            r_state     <= S_IDLE;
            r_db_cnt    <= '0;
            r_step_held <= 1'b0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_db_cnt    <= '0;
          r_step_held <= 1'b0;
        end
      endcase
    end
  end

  // Direction debouncer: the synced level must differ from the accepted level for
  // DEBOUNCE_CYCLES+1 consecutive samples, matching the step path's press latency.
  assign w_dir_accept = (w_dir_lvl != r_dir_db) && (r_dir_cnt == DB_FULL);
  assign w_dir_toggle = w_dir_accept && w_dir_lvl;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dir_cnt     <= '0;
      r_dir_db      <= 1'b0;
      r_reverse     <= 1'b0;
      r_step_pulse  <= 1'b0;
      r_pulse_defer <= 1'b0;
    end else begin
      if (w_dir_lvl == r_dir_db) begin
        r_dir_cnt <= '0;
      end else if (w_dir_accept) begin
        r_dir_db  <= w_dir_lvl;
        r_dir_cnt <= '0;
      end else begin
        r_dir_cnt <= r_dir_cnt + DB_ONE;
      end

      if (w_dir_toggle) r_reverse <= ~r_reverse;

      // A pulse colliding with a toggle waits one cycle so the counter steps the new way.
      r_step_pulse  <= r_pulse_defer | (w_step_due & ~w_dir_toggle);
      r_pulse_defer <= w_step_due & (w_dir_toggle | r_pulse_defer);
    end
  end

  assign step_pulse = r_step_pulse;
  assign reverse    = r_reverse;
  assign step_held  = r_step_held;

endmodule
